// File: rtl/impl_axi_sram_slave_if.sv
// AXI4 bus bundle shared by crossbar ports and endpoints.
// Master drives requests, Slave drives responses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
    output aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
    output aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
    output ar_cache, ar_prot, ar_qos, ar_region, ar_user,
    output ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
    input aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
    input aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
    input ar_cache, ar_prot, ar_qos, ar_region, ar_user,
    input ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input r_ready
  );
endinterface

// File: rtl/impl_axi_sram_slave.sv
// AXI4 scratch-RAM endpoint: one burst at a time over a flop array,
// FIXED/INCR/WRAP with strobes, OKAY/SLVERR per beat.
module impl_axi_sram_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned MEM_BYTES      = 4096,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic   clk_i,
  input logic   rst_ni,
  AXI_BUS.Slave slv
);
  localparam int unsigned AW    = AXI_ADDR_WIDTH;
  localparam int unsigned DW    = AXI_DATA_WIDTH;
  localparam int unsigned IW    = AXI_ID_WIDTH;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned NBW   = $clog2(NB);
  localparam int unsigned MAW   = $clog2(MEM_BYTES);
  localparam int unsigned WORDS = MEM_BYTES / NB;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;
  typedef logic [MAW-NBW-1:0] idx_t;

  function automatic idx_t mem_idx(input logic [AW-1:0] a);
    return a[MAW-1:NBW];
  endfunction

  // BASE_ADDR is MEM_BYTES-aligned, so a tag compare is the range test.
  function automatic logic in_range(input logic [AW-1:0] a);
    return a[AW-1:MAW] == BASE_ADDR[AW-1:MAW];
  endfunction

  function automatic logic burst_bad(
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || (size > 3'(NBW)) ||
           (burst == 2'b10 && !wrap_ok);
  endfunction

  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] a,
    input logic [7:0]    len,
    input logic [2:0]    size,
    input logic [1:0]    burst
  );
    logic [AW-1:0] step, inc, mask, nxt;
    step = AW'(1) << size;
    inc  = (a & ~(step - AW'(1))) + step;
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    unique case (burst)
      2'b00:   nxt = a;
      2'b10:   nxt = (a & ~mask) | (inc & mask);
      default: nxt = inc;
    endcase
    return nxt;
  endfunction

  state_e          state_q, state_d;
  logic            rdy_q, w_ready_q, b_valid_q, r_valid_q;
  logic            wr_prio_q;
  logic [IW-1:0]   id_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q, cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic            bad_q, err_q;
  logic [1:0]      b_resp_q, r_resp_q;
  logic [DW-1:0]   r_data_q;
  logic            r_last_q;
  logic [NB-1:0][7:0] mem_q [WORDS];

  logic          aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic          last_beat, wr_ok, werr, rd_ok;
  logic [AW-1:0] nxt_addr, rd_addr;
  logic [DW-1:0] rd_word;

  assign slv.aw_ready = rdy_q & (~slv.ar_valid | wr_prio_q);
  assign slv.ar_ready = rdy_q & (~slv.aw_valid | ~wr_prio_q);
  assign slv.w_ready  = w_ready_q;
  assign slv.b_valid  = b_valid_q;
  assign slv.b_id     = id_q;
  assign slv.b_resp   = b_resp_q;
  assign slv.b_user   = AXI_USER_WIDTH'(0);
  assign slv.r_valid  = r_valid_q;
  assign slv.r_id     = id_q;
  assign slv.r_data   = r_data_q;
  assign slv.r_resp   = r_resp_q;
  assign slv.r_last   = r_last_q;
  assign slv.r_user   = AXI_USER_WIDTH'(0);

  assign aw_hs = slv.aw_valid & slv.aw_ready;
  assign ar_hs = slv.ar_valid & slv.ar_ready;
  assign w_hs  = slv.w_valid & w_ready_q;
  assign b_hs  = b_valid_q & slv.b_ready;
  assign r_hs  = r_valid_q & slv.r_ready;

  always_comb begin
    last_beat = cnt_q == len_q;
    nxt_addr  = next_addr(addr_q, len_q, size_q, burst_q);
    wr_ok     = !bad_q && in_range(addr_q);
    werr      = !wr_ok || (slv.w_last != last_beat);
    rd_addr   = nxt_addr;
    rd_ok     = !bad_q && in_range(nxt_addr);
    if (state_q == IDLE) begin
      rd_addr = slv.ar_addr;
      rd_ok   = !burst_bad(slv.ar_len, slv.ar_size, slv.ar_burst) &&
                in_range(slv.ar_addr);
    end
    rd_word = mem_q[mem_idx(rd_addr)];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs)      state_d = WR_DATA;
        else if (ar_hs) state_d = RD_DATA;
      end
      WR_DATA: if (w_hs && last_beat) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = IDLE;
      RD_DATA: if (r_hs && r_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      w_ready_q <= 1'b0;
      b_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= state_d == IDLE;
      w_ready_q <= state_d == WR_DATA;
      b_valid_q <= state_d == WR_RESP;
      r_valid_q <= state_d == RD_DATA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_prio_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      bad_q     <= 1'b0;
      err_q     <= 1'b0;
      b_resp_q  <= OKAY;
      r_resp_q  <= OKAY;
      r_data_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_hs) begin
            id_q      <= slv.aw_id;
            addr_q    <= slv.aw_addr;
            len_q     <= slv.aw_len;
            size_q    <= slv.aw_size;
            burst_q   <= slv.aw_burst;
            bad_q     <= burst_bad(slv.aw_len, slv.aw_size, slv.aw_burst);
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_prio_q <= 1'b0;
          end else if (ar_hs) begin
            id_q      <= slv.ar_id;
            addr_q    <= slv.ar_addr;
            len_q     <= slv.ar_len;
            size_q    <= slv.ar_size;
            burst_q   <= slv.ar_burst;
            bad_q     <= burst_bad(slv.ar_len, slv.ar_size, slv.ar_burst);
            cnt_q     <= '0;
            wr_prio_q <= 1'b1;
            r_data_q  <= rd_ok ? rd_word : '0;
            r_resp_q  <= rd_ok ? OKAY : SLVERR;
            r_last_q  <= slv.ar_len == 8'd0;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            err_q <= err_q | werr;
            if (last_beat) begin
              b_resp_q <= (err_q | werr) ? SLVERR : OKAY;
            end else begin
              addr_q <= nxt_addr;
              cnt_q  <= cnt_q + 8'd1;
            end
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            if (r_last_q) begin
              r_data_q <= '0;
              r_resp_q <= OKAY;
              r_last_q <= 1'b0;
            end else begin
              addr_q   <= nxt_addr;
              cnt_q    <= cnt_q + 8'd1;
              r_data_q <= rd_ok ? rd_word : '0;
              r_resp_q <= rd_ok ? OKAY : SLVERR;
              r_last_q <= (cnt_q + 8'd1) == len_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset so data survives a bus reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_hs && wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (slv.w_strb[b]) mem_q[mem_idx(addr_q)][b] <= slv.w_data[8*b +: 8];
      end
    end
  end
endmodule
